pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer for the core's fetch stage. Holds the PC, drives the
//  5-bit index into the branch-target LUT and adds the returned signed offset on
//  taken branches. Runs an IDLE/RUN/HALT state machine with start/done handshake,
//  stall hold and a saturating run-cycle counter for the test harness.
// PARAMETERS
//  D         12   PC width; LUT targets are D-bit two's-complement relative offsets
//  START_PC  0    PC value loaded on each start
//  CNT_W     16   width of the run-cycle counter
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  reset       in   1      synchronous, active-high
//  start       in   1      begin execution (sampled in IDLE or HALT)
//  stall       in   1      hold PC and state this cycle
//  halt_req    in   1      decoded halt instruction at current PC
//  branch      in   1      decoded branch instruction at current PC
//  taken       in   1      branch condition true
//  lut_idx     in   5      LUT index field of the branch instruction
//  lut_addr    out  5      to branch-target LUT addr (combinational = lut_idx)
//  lut_target  in   D      signed offset returned by the LUT
//  link        in   1      branch-and-link qualifier (PC_LINK_EN only)
//  ret         in   1      return-from-link instruction (PC_LINK_EN only)
//  prog_ctr    out  D      current PC (registered)
//  fetch_en    out  1      high in RUN when not stalled
//  done        out  1      high in HALT (registered)
//  run_cycles  out  CNT_W  cycles spent in RUN, saturating
// BEHAVIOUR
//  - Reset: state=IDLE, prog_ctr=0, done=0, run_cycles=0, link_reg=0; fetch_en=0.
//  - IDLE: start -> RUN next cycle, prog_ctr<=START_PC, run_cycles<=0.
//  - RUN, stall=1: prog_ctr, state and all other control inputs ignored;
//    run_cycles still increments.
//  - RUN, stall=0, priority: halt_req > ret > (branch&taken) > sequential.
//     halt_req: state<=HALT, prog_ctr held, done=1 from next cycle.
//     branch&taken: prog_ctr <= prog_ctr + lut_target (mod 2^D, wraps both ways).
//     otherwise (incl. branch&!taken): prog_ctr <= prog_ctr + 1 (mod 2^D).
//  - Offset 0 (LUT default) is legal: PC holds; sequencer stays in RUN.
//  - Latency: next PC visible 1 cycle after the deciding edge; lut_addr has no
//    register, so lut_target must settle within the cycle.
//  - run_cycles: +1 every RUN cycle; saturates at 2^CNT_W-1; frozen in HALT.
//  - HALT: fetch_en=0, done=1, prog_ctr held; start -> RUN at START_PC,
//    done deasserts and run_cycles clears on that same edge.
//  - start in RUN is ignored. reset in any state, incl. mid-stall, wins over all.
// CONFIGURATION
//  PC_LINK_EN defined: 1-entry link register. On taken branch with link=1,
//   link_reg <= prog_ctr+1 together with the branch. On ret=1 (not stalled,
//   no halt_req), prog_ctr <= link_reg. ret with link=1 in the same cycle:
//   ret wins, and link_reg is unchanged.
//  PC_LINK_EN undefined: no link register; link and ret ports exist but are
//   ignored; a taken branch with link=1 behaves as a plain taken branch.
// STRUCTURE
//  - pc_seq_pkg: typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;
//    localparam LUT_IDX_W = 5.
//  - One sub-module: pc_sat_counter (CNT_W, clear, inc, saturating).
//  - The LUT itself stays outside; the top level wires lut_addr/lut_target.
// TESTING
//  1. reset, start@cyc2; no branches for 5 cycles
//     -> prog_ctr 0,1,2,3,4,5; fetch_en=1; run_cycles=5.
//  2. PC=20, branch=taken=1, lut_target=-258 (D=12)
//     -> next prog_ctr=3858 (wrap); PC=4095, sequential -> 0.
//  3. PC=7, halt_req=branch=taken=1 -> HALT, prog_ctr=7, done=1 next cycle;
//     start -> prog_ctr=0, done=0.
//  4. stall=1 for 3 cycles at PC=9 with branch&taken -> PC stays 9;
//     run_cycles+3; taken branch applies on the first unstalled cycle.
//  5. CNT_W=4: 20 RUN cycles -> run_cycles=15 held; reset mid-RUN -> all zero, IDLE.
//  6. PC_LINK_EN: PC=10 branch&taken&link, target=5 -> PC=15; ret -> PC=11;
//     without macro, same ret -> PC=16.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned LUT_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module pc_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count up until all-ones, then hold.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: IDLE/RUN/HALT control, LUT-relative branches,
// stall hold and a saturating run-cycle counter.
// Optional build macro PC_LINK_EN adds a 1-entry link register for ret.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D        = 12,
    parameter int unsigned START_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 branch,
    input  logic                 taken,
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [LUT_IDX_W-1:0] lut_addr,
    input  logic [D-1:0]         lut_target,
    input  logic                 link,
    input  logic                 ret,
    output logic [D-1:0]         prog_ctr,
    output logic                 fetch_en,
    output logic                 done,
    output logic [CNT_W-1:0]     run_cycles
);

    pc_state_t      state_q, state_d;
    logic [D-1:0]   pc_d;
    logic           cnt_clear;
    logic           cnt_inc;

`ifdef PC_LINK_EN
    logic [D-1:0]   link_q, link_d;
`else
    logic           unused_link_ports;
    assign unused_link_ports = link ^ ret;
`endif

    // The LUT is external and unregistered; its target must settle within the cycle.
    assign lut_addr = lut_idx;

    // State, PC and done registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prog_ctr <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prog_ctr <= pc_d;
            done     <= (state_d == HALT);
        end
    end

`ifdef PC_LINK_EN
    // Link register holds the return address of the last branch-and-link.
    always_ff @(posedge clk) begin
        if (reset) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end
`endif

    // Next-state, next-PC and counter control; lut_target is two's complement,
    // so a plain D-bit add gives wrapping relative branches in both directions.
    always_comb begin
        state_d   = state_q;
        pc_d      = prog_ctr;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        fetch_en  = 1'b0;
`ifdef PC_LINK_EN
        link_d    = link_q;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = D'(START_PC);
                    cnt_clear = 1'b1;
                end
            end
            RUN: begin
                cnt_inc = 1'b1;
                if (!stall) begin
                    fetch_en = 1'b1;
                    if (halt_req) begin
                        state_d = HALT;
`ifdef PC_LINK_EN
                    end else if (ret) begin
                        pc_d = link_q;
`endif
                    end else if (branch && taken) begin
                        pc_d = D'(prog_ctr + lut_target);
`ifdef PC_LINK_EN
                        if (link) begin
                            link_d = D'(prog_ctr + D'(1));
                        end
`endif
                    end else begin
                        pc_d = D'(prog_ctr + D'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Cycles spent in RUN, cleared on each start.
    pc_sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (run_cycles)
    );

endmodule
